// File: rtl/decoder_pipe_if.sv
// Handshake bundle for decoder_pipe: request side (in_*) and decoded-result side (out_*).
// The slave modport is the decoder's view; master is the driver/consumer view.
interface decoder_pipe_if #(
  parameter int unsigned ADDR_W = 6
) ();
  localparam int unsigned OUT_W = 2 ** ADDR_W;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] addr;
  logic              en;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  onehot;
  logic [ADDR_W-1:0] out_idx;
  logic              out_zero;
  logic [7:0]        sup_cnt;

  modport slave (
    input  in_valid, addr, en, out_ready,
    output in_ready, out_valid, onehot, out_idx, out_zero, sup_cnt
  );

  modport master (
    output in_valid, addr, en, out_ready,
    input  in_ready, out_valid, onehot, out_idx, out_zero, sup_cnt
  );
endinterface

// File: rtl/decoder_pipe.sv
// Address-to-onehot decoder behind a 2-entry FIFO with valid/ready handshakes on both sides.
// Outputs decode the FIFO head combinationally; sup_cnt counts accepted all-zero decodes.
module decoder_pipe #(
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned ZERO_PROTECT = 1
) (
  input logic           clk,
  input logic           rst_n,
  decoder_pipe_if.slave bus
);
  localparam int unsigned OUT_W = 2 ** ADDR_W;

  // Entry layout: {en, addr}
  typedef logic [ADDR_W:0] entry_t;

  entry_t            mem_q [2];
  entry_t            mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic [7:0]        sup_cnt_q, sup_cnt_d;

  logic              push, pop, req_zero, out_valid, head_en;
  logic [ADDR_W-1:0] head_addr;
  logic [OUT_W-1:0]  onehot;

  function automatic logic decodes_zero(logic [ADDR_W-1:0] a, logic e);
    return !e || ((ZERO_PROTECT != 0) && (a == '0));
  endfunction

  always_comb begin
    out_valid = (count_q != 2'd0);
    head_addr = mem_q[rd_ptr_q][ADDR_W-1:0];
    head_en   = mem_q[rd_ptr_q][ADDR_W];
    push      = bus.in_valid & in_ready_q;
    pop       = out_valid & bus.out_ready;
    req_zero  = decodes_zero(bus.addr, bus.en);

    onehot = '0;
    if (out_valid && !decodes_zero(head_addr, head_en)) onehot[head_addr] = 1'b1;

    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    sup_cnt_d = sup_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = {bus.en, bus.addr};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Registered so in_ready never depends combinationally on the inputs.
    in_ready_d = (count_d != 2'd2);

    if (push && req_zero && (sup_cnt_q != 8'hFF)) sup_cnt_d = sup_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
      sup_cnt_q  <= 8'd0;
    end else begin
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      sup_cnt_q  <= sup_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.onehot    = onehot;
  assign bus.out_idx   = out_valid ? head_addr : '0;
  assign bus.out_zero  = out_valid && (onehot == '0);
  assign bus.sup_cnt   = sup_cnt_q;

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed bench for decoder_pipe: table of single transfers plus hand-written sequences for
// backpressure, simultaneous push/pop, saturation and asynchronous reset.
module tb_decoder_pipe;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   exp_sup;
  int   exp_sup_nz;

  decoder_pipe_if #(.ADDR_W(6)) bus ();
  decoder_pipe_if #(.ADDR_W(6)) nz ();

  decoder_pipe #(.ADDR_W(6), .ZERO_PROTECT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  decoder_pipe #(.ADDR_W(6), .ZERO_PROTECT(0)) dut_nz (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (nz)
  );

  assign nz.in_valid  = bus.in_valid;
  assign nz.addr      = bus.addr;
  assign nz.en        = bus.en;
  assign nz.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic        en;
    logic [63:0] oh;
    logic [63:0] oh_nz;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; exp_sup = 0; exp_sup_nz = 0;
    bus.in_valid = 1'b0; bus.addr = '0; bus.en = 1'b0; bus.out_ready = 1'b1;

    tbl[0] = '{6'h25, 1'b1, 64'h0000_0020_0000_0000, 64'h0000_0020_0000_0000};
    tbl[1] = '{6'h00, 1'b1, 64'h0,                   64'h1};
    tbl[2] = '{6'h3F, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    tbl[3] = '{6'h01, 1'b1, 64'h2,                   64'h2};
    tbl[4] = '{6'h10, 1'b0, 64'h0,                   64'h0};
    tbl[5] = '{6'h20, 1'b1, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000};

    // Reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst in_ready",  64'(bus.in_ready), 64'd0);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst onehot",    bus.onehot, 64'd0);
    check("rst out_idx",   64'(bus.out_idx), 64'd0);
    check("rst out_zero",  64'(bus.out_zero), 64'd0);
    check("rst sup_cnt",   64'(bus.sup_cnt), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #4 rst_n = 1'b1;
    #1 check("in_ready before first edge", 64'(bus.in_ready), 64'd0);
    tick();
    check("in_ready after first edge", 64'(bus.in_ready), 64'd1);

    // Table: one request at a time, downstream always ready
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.addr = tbl[i].addr; bus.en = tbl[i].en;
      tick();
      bus.in_valid = 1'b0;
      if (tbl[i].oh == 64'd0) exp_sup++;
      if (tbl[i].oh_nz == 64'd0) exp_sup_nz++;
      check($sformatf("tbl%0d out_valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("tbl%0d onehot", i), bus.onehot, tbl[i].oh);
      check($sformatf("tbl%0d out_idx", i), 64'(bus.out_idx), 64'(tbl[i].addr));
      check($sformatf("tbl%0d out_zero", i), 64'(bus.out_zero), 64'(tbl[i].oh == 64'd0));
      check($sformatf("tbl%0d nz onehot", i), nz.onehot, tbl[i].oh_nz);
      check($sformatf("tbl%0d sup_cnt", i), 64'(bus.sup_cnt), 64'(exp_sup));
      check($sformatf("tbl%0d nz sup_cnt", i), 64'(nz.sup_cnt), 64'(exp_sup_nz));
      tick();
      check($sformatf("tbl%0d drained", i), 64'(bus.out_valid), 64'd0);
      check($sformatf("tbl%0d idle out_idx", i), 64'(bus.out_idx), 64'd0);
    end

    // Backpressure: third request must be refused, head must hold
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.en = 1'b1; bus.addr = 6'h01;
    tick();
    bus.addr = 6'h02;
    tick();
    bus.addr = 6'h03;
    check("bp full in_ready", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp stall%0d onehot", i), bus.onehot, 64'h2);
      check($sformatf("bp stall%0d in_ready", i), 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    check("bp second head onehot", bus.onehot, 64'h4);
    check("bp second head idx", 64'(bus.out_idx), 64'd2);
    check("bp in_ready after pop", 64'(bus.in_ready), 64'd1);
    tick();
    check("bp drained, 0x03 never accepted", 64'(bus.out_valid), 64'd0);

    // Simultaneous push and pop at count 1
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.addr = 6'h05; bus.en = 1'b1;
    tick();
    bus.out_ready = 1'b1; bus.addr = 6'h3F;
    tick();
    bus.in_valid = 1'b0;
    check("pp out_valid", 64'(bus.out_valid), 64'd1);
    check("pp onehot", bus.onehot, 64'h8000_0000_0000_0000);
    check("pp in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    check("pp drained", 64'(bus.out_valid), 64'd0);

    // Sweep all addresses, streaming one per cycle
    for (int e = 1; e >= 0; e--) begin
      bus.in_valid = 1'b1; bus.en = 1'(e);
      for (int a = 0; a < 64; a++) begin
        bus.addr = 6'(a);
        tick();
        if (e == 1 && a != 0) begin
          check($sformatf("sweep en1 a%0d onehot", a), bus.onehot, 64'd1 << a);
          check($sformatf("sweep en1 a%0d bits", a), 64'($countones(bus.onehot)), 64'd1);
        end else begin
          exp_sup++;
          check($sformatf("sweep en%0d a%0d zero", e, a), bus.onehot, 64'd0);
          check($sformatf("sweep en%0d a%0d out_zero", e, a), 64'(bus.out_zero), 64'd1);
        end
      end
    end
    check("sweep sup_cnt", 64'(bus.sup_cnt), 64'(exp_sup));

    // 256 all-zero requests must saturate the counter
    bus.en = 1'b0;
    for (int i = 0; i < 256; i++) tick();
    bus.in_valid = 1'b0;
    tick();
    check("sup_cnt saturated", 64'(bus.sup_cnt), 64'd255);

    // Asynchronous reset with the FIFO full
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.en = 1'b1; bus.addr = 6'h11;
    tick();
    bus.addr = 6'h12;
    tick();
    bus.in_valid = 1'b0;
    check("ar full in_ready", 64'(bus.in_ready), 64'd0);
    #3 rst_n = 1'b0;
    #1;
    check("ar out_valid immediate", 64'(bus.out_valid), 64'd0);
    check("ar onehot immediate", bus.onehot, 64'd0);
    check("ar out_zero immediate", 64'(bus.out_zero), 64'd0);
    check("ar sup_cnt immediate", 64'(bus.sup_cnt), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("ar in_ready held low", 64'(bus.in_ready), 64'd0);
    tick();
    check("ar in_ready after edge", 64'(bus.in_ready), 64'd1);
    check("ar no stale out_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.addr = 6'h07;
    tick();
    bus.in_valid = 1'b0;
    check("ar fresh head onehot", bus.onehot, 64'h80);
    check("ar fresh head idx", 64'(bus.out_idx), 64'd7);
    tick();
    check("ar no stale after pop", 64'(bus.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
DECODER_PIPE -- requirements
Module: decoder_pipe

Parameters
REQ-001 The block SHALL have parameter ADDR_W, default 6, giving the address width; legal range is 1..8.
REQ-002 The block SHALL have parameter ZERO_PROTECT, default 1; when 1, address 0 decodes to an all-zero output (hard-wired-zero register).
REQ-003 The block SHALL derive OUT_W = 2**ADDR_W, which is not overridable.

Interface
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset; assertion is asynchronous and release is synchronous to clk.
REQ-006 in_valid  input  1  upstream has a decode request.
REQ-007 in_ready  output  1  block can accept a request; driven from registers only.
REQ-008 addr  input  ADDR_W  address to decode.
REQ-009 en  input  1  request enable; 0 forces an all-zero decode.
REQ-010 out_valid  output  1  onehot, out_idx and out_zero are valid.
REQ-011 out_ready  input  1  downstream accepts the output.
REQ-012 onehot  output  OUT_W  decoded word; bit k is set iff the decoded address is k.
REQ-013 out_idx  output  ADDR_W  address of the head entry, passed through undecoded.
REQ-014 out_zero  output  1  head entry decodes to all zeros.
REQ-015 sup_cnt  output  8  saturating count of accepted all-zero decodes.

Function
REQ-016 A transfer SHALL occur on an input when valid and ready are both high at a rising edge; this applies to the in_ and out_ pairs independently.
REQ-017 The block SHALL store accepted {addr, en} pairs in a 2-entry FIFO, with count held in the range 0..2.
REQ-018 in_ready SHALL be 1 when count < 2 and 0 when count == 2; a push is therefore never made when full.
REQ-019 out_valid SHALL be 1 iff count > 0; the outputs SHALL decode the head entry combinationally from registered state.
REQ-020 Latency SHALL be one cycle: a request accepted at edge N is presented with out_valid=1 after edge N when the FIFO was empty.
REQ-021 onehot SHALL be 0 when out_valid=0, when head en=0, or when ZERO_PROTECT=1 and head addr=0; otherwise onehot SHALL equal 1 << head addr.
REQ-022 out_zero SHALL equal out_valid AND (onehot == 0).
REQ-023 out_idx SHALL show the head address while out_valid=1 and 0 otherwise.
REQ-024 A simultaneous push and pop with count==1 SHALL leave count at 1 and make the new entry the head.
REQ-025 A simultaneous push and pop with count==0 SHALL NOT occur, because out_valid=0 blocks the pop; the push alone takes count to 1.
REQ-026 A pop with count==2 SHALL promote the second entry to head, leave count at 1, and raise in_ready on the following cycle.
REQ-027 Outputs SHALL hold stable while out_valid=1 and out_ready=0 (backpressure).
REQ-028 sup_cnt SHALL increment by 1 on each input transfer whose {addr, en} would decode to all zeros, and SHALL saturate at 255.
REQ-029 The FIFO pointers SHALL wrap modulo 2.

Reset
REQ-030 While rst_n=0: count=0, pointers=0, sup_cnt=0, in_ready=0, out_valid=0, onehot=0, out_idx=0, out_zero=0.
REQ-031 in_ready SHALL rise at the first clk edge after rst_n is released.
REQ-032 Assertion of rst_n mid-transfer SHALL discard all stored entries immediately, with no pop reported.

Verification (ADDR_W=6, ZERO_PROTECT=1)
REQ-033 Push addr=0x25 en=1 with out_ready=1 -> one cycle later out_valid=1, onehot=bit 37 only, out_idx=0x25, out_zero=0.
REQ-034 Push addr=0 en=1 -> onehot=0, out_zero=1, sup_cnt increments 0->1; repeat with ZERO_PROTECT=0 -> onehot=1, sup_cnt unchanged.
REQ-035 Hold out_ready=0 and push 0x01, 0x02, 0x03 on back-to-back cycles -> only 0x01 and 0x02 are accepted, in_ready=0; onehot stays at bit 1 across all stall cycles.
REQ-036 With count=1, push 0x3F while popping -> next cycle count=1, onehot=bit 63; then push 256 all-zero requests -> sup_cnt=255.
REQ-037 Assert rst_n=0 with count=2, asynchronous to clk -> out_valid and in_ready go to 0 immediately without waiting for a clock edge; after release in_ready=1 on the next edge and no stale entries appear.
REQ-038 Sweep all 64 addresses with en=1 and then en=0 -> exactly one onehot bit is set per enabled nonzero address, and onehot=0 for every disabled request.
